// File: rtl/lc3_mmio_pkg.sv
// Package: lc3_mmio_pkg
// Shared types and constants for the LC-3 memory / I-O bus controller.
//   - bus_state_t  : bus FSM states
//   - *_OFS        : register offsets within a 4-word channel window
//   - *_BIT        : status register bit positions
//   - INT_*        : interrupt priority / vector constants
//   - rxsr_word()  : packs the RX status register read value
// Optional feature macro: LC3_MMIO_TIMER_EN (timer addresses/vector below).
package lc3_mmio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        IO   = 2'd2,
        DONE = 2'd3
    } bus_state_t;

    localparam logic [1:0] RXSR_OFS = 2'd0;
    localparam logic [1:0] RXDR_OFS = 2'd1;
    localparam logic [1:0] TXSR_OFS = 2'd2;
    localparam logic [1:0] TXDR_OFS = 2'd3;

    localparam int unsigned RXSR_NE_BIT    = 15;
    localparam int unsigned RXSR_IE_BIT    = 14;
    localparam int unsigned RXSR_OVF_BIT   = 13;
    localparam int unsigned TXSR_EMPTY_BIT = 15;
    localparam int unsigned TMSR_EXP_BIT   = 15;
    localparam int unsigned TMSR_IE_BIT    = 14;

    localparam logic [2:0]  INT_PRIO     = 3'd4;
    localparam logic [7:0]  INT_VEC_BASE = 8'h80;
    localparam logic [7:0]  TIMER_VEC    = 8'hFF;

    localparam logic [15:0] TMR_ADDR  = 16'hFFF0;
    localparam logic [15:0] TMSR_ADDR = 16'hFFF1;

    function automatic logic [15:0] rxsr_word(input logic       not_empty,
                                              input logic       ie,
                                              input logic       ovf,
                                              input logic [3:0] occ);
        logic [15:0] w;
        w                = '0;
        w[RXSR_NE_BIT]   = not_empty;
        w[RXSR_IE_BIT]   = ie;
        w[RXSR_OVF_BIT]  = ovf;
        w[3:0]           = occ;
        return w;
    endfunction

endpackage

// File: rtl/lc3_mmio_rxfifo.sv
// Module: lc3_mmio_rxfifo
// Per-channel receive FIFO (byte wide, DEPTH entries, DEPTH a power of 2).
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   valid_i/data_i incoming byte from the device
//   ready_o        byte will be accepted this cycle
//   pop_i          consume head byte (ignored when empty)
//   clr_ovf_i      clear the sticky overflow flag
//   data_o         head byte (meaningless when empty)
//   count_o        occupancy
//   empty_o        FIFO empty
//   ovf_o          sticky: a byte was offered while no space was available
module lc3_mmio_rxfifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    input  logic                     clr_ovf_i,
    output logic                     ready_o,
    output logic [7:0]               data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     ovf_o
);

    localparam int unsigned    AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = (AW)'(1);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          full, do_pop, do_push;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign ready_o = !full || do_pop;
    assign do_push = valid_i && ready_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            ovf_q <= (ovf_q && !clr_ovf_i) || (valid_i && !ready_o);
        end
    end

endmodule

// File: rtl/lc3_mmio_bus.sv
// Module: lc3_mmio_bus
// LC-3 bus controller: routes core accesses to main memory (with MEM_WAIT
// wait states) or to NUM_CH console channels, each with an RX FIFO, a TX
// holding register and an interrupt enable. Channel c occupies
// IO_BASE+4c .. IO_BASE+4c+3 (RXSR, RXDR, TXSR, TXDR).
// Ports:
//   clk, rst (async, active-low)
//   cpu_en/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata/cpu_rdy  core side
//   mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata          memory side
//   rx_valid/rx_data -> rx_ready                           device RX
//   tx_valid/tx_data <- tx_ready                           device TX
//   irq/intv/intp                                          interrupt request
// Optional feature: define LC3_MMIO_TIMER_EN to add the interval timer
// (TMR at FFF0, TMSR at FFF1, vector 8'hFF, priority over all channels).
module lc3_mmio_bus
    import lc3_mmio_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MEM_WAIT   = 2,
    parameter logic [15:0] IO_BASE    = 16'hFE00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_en,
    input  logic                  cpu_we,
    input  logic [15:0]           cpu_addr,
    input  logic [15:0]           cpu_wdata,
    output logic [15:0]           cpu_rdata,
    output logic                  cpu_rdy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [15:0]           mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic [NUM_CH-1:0]     rx_valid,
    input  logic [8*NUM_CH-1:0]   rx_data,
    output logic [NUM_CH-1:0]     rx_ready,
    output logic [NUM_CH-1:0]     tx_valid,
    output logic [8*NUM_CH-1:0]   tx_data,
    input  logic [NUM_CH-1:0]     tx_ready,
    output logic                  irq,
    output logic [7:0]            intv,
    output logic [2:0]            intp
);

    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] IO_SPAN = 16'(4 * NUM_CH);

    bus_state_t  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        we_q, we_d;

    logic [4:0]         ofs;
    logic [1:0]         reg_sel;
    logic [2:0]         ch_sel;
    logic               io_ch_acc;
    logic [NUM_CH-1:0]  ch_hit;
    logic [NUM_CH-1:0]  req;
    logic [15:0]        chan_rd [NUM_CH];
    logic [15:0]        rd_val;

    function automatic logic in_chan_range(input logic [15:0] a);
        logic [15:0] d;
        d = a - IO_BASE;
        return (a >= IO_BASE) && (d < IO_SPAN);
    endfunction

    function automatic logic is_io(input logic [15:0] a);
`ifdef LC3_MMIO_TIMER_EN
        return in_chan_range(a) || (a == TMR_ADDR) || (a == TMSR_ADDR);
`else
        return in_chan_range(a);
`endif
    endfunction

    assign ofs       = 5'(addr_q - IO_BASE);
    assign reg_sel   = ofs[1:0];
    assign ch_sel    = ofs[4:2];
    assign io_ch_acc = (state_q == IO) && in_chan_range(addr_q);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic          pop, wr_rxsr, wr_txdr, empty, ovf;
        logic [7:0]    head;
        logic [CW-1:0] count;
        logic          ie_q, tx_v_q;
        logic [7:0]    tx_d_q;
        logic [15:0]   rd;

        assign ch_hit[c] = io_ch_acc && (ch_sel == 3'(c));
        assign pop       = ch_hit[c] && !we_q && (reg_sel == RXDR_OFS);
        assign wr_rxsr   = ch_hit[c] &&  we_q && (reg_sel == RXSR_OFS);
        assign wr_txdr   = ch_hit[c] &&  we_q && (reg_sel == TXDR_OFS);

        lc3_mmio_rxfifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i     (clk),
            .rst_ni    (rst),
            .valid_i   (rx_valid[c]),
            .data_i    (rx_data[8*c +: 8]),
            .pop_i     (pop),
            .clr_ovf_i (wr_rxsr),
            .ready_o   (rx_ready[c]),
            .data_o    (head),
            .count_o   (count),
            .empty_o   (empty),
            .ovf_o     (ovf)
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ie_q   <= 1'b0;
                tx_v_q <= 1'b0;
                tx_d_q <= '0;
            end else begin
                if (wr_rxsr) ie_q <= wdata_q[RXSR_IE_BIT];
                // Holding register is single-entry: writes while full are dropped.
                if (tx_v_q) begin
                    if (tx_ready[c]) tx_v_q <= 1'b0;
                end else if (wr_txdr) begin
                    tx_v_q <= 1'b1;
                    tx_d_q <= wdata_q[7:0];
                end
            end
        end

        always_comb begin
            rd = '0;
            if (!we_q) begin
                case (reg_sel)
                    RXSR_OFS: rd = rxsr_word(!empty, ie_q, ovf, 4'(count));
                    RXDR_OFS: rd = {8'h00, empty ? 8'h00 : head};
                    TXSR_OFS: rd[TXSR_EMPTY_BIT] = !tx_v_q;
                    default:  rd = '0;
                endcase
            end
        end

        assign chan_rd[c]         = rd;
        assign req[c]             = ie_q && !empty;
        assign tx_valid[c]        = tx_v_q;
        assign tx_data[8*c +: 8]  = tx_d_q;
    end

`ifdef LC3_MMIO_TIMER_EN
    logic [15:0] tmr_q, tcnt_q;
    logic        texp_q, tie_q;
    logic        tmr_wr, tmsr_wr;

    assign tmr_wr  = (state_q == IO) && we_q && (addr_q == TMR_ADDR);
    assign tmsr_wr = (state_q == IO) && we_q && (addr_q == TMSR_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q  <= '0;
            tcnt_q <= '0;
            texp_q <= 1'b0;
            tie_q  <= 1'b0;
        end else begin
            if (tmsr_wr) tie_q <= wdata_q[TMSR_IE_BIT];
            if (tmr_wr) begin
                tmr_q  <= wdata_q;
                tcnt_q <= wdata_q;
                if (tmsr_wr) texp_q <= 1'b0;
            end else if (tmr_q != '0 && tcnt_q == '0) begin
                texp_q <= 1'b1;
                tcnt_q <= tmr_q;
            end else begin
                if (tmr_q != '0) tcnt_q <= tcnt_q - 16'd1;
                if (tmsr_wr)     texp_q <= 1'b0;
            end
        end
    end
`endif

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i]) rd_val = chan_rd[i];
        end
`ifdef LC3_MMIO_TIMER_EN
        if (state_q == IO && !we_q && addr_q == TMR_ADDR)  rd_val = tmr_q;
        if (state_q == IO && !we_q && addr_q == TMSR_ADDR) rd_val = {texp_q, tie_q, 14'd0};
`endif
    end

    always_comb begin
        logic found;
        found = 1'b0;
        irq   = 1'b0;
        intv  = '0;
        intp  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (req[i] && !found) begin
                found = 1'b1;
                intv  = INT_VEC_BASE + 8'(i);
            end
        end
`ifdef LC3_MMIO_TIMER_EN
        if (tie_q && texp_q) begin
            found = 1'b1;
            intv  = TIMER_VEC;
        end
`endif
        irq = found;
        if (found) intp = INT_PRIO;
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_en) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    wait_d  = 4'(MEM_WAIT);
                    state_d = is_io(cpu_addr) ? IO : MEM;
                end
            end
            MEM: begin
                if (wait_q == '0) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            IO: begin
                rdata_d = rd_val;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode straight from the state register so reset drops them at once.
    assign mem_en    = (state_q == MEM);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = (mem_en && we_q) ? wdata_q : '0;
    assign cpu_rdy   = (state_q == DONE);
    assign cpu_rdata = cpu_rdy ? rdata_q : '0;

endmodule
